fsm_ascon_encrypt: RTL and testbench

Main control FSM for the full Ascon-128 authenticated encryption. It replaces the init-only controller and drives the round counter (p12/p6 double-init counter) and the permutation datapath. It runs four phases in order: initialisation, associated data (AD), plaintext (PT) and finalisation. It handshakes with the data source block by block and flags ciphertext and tag availability.

---
 rtl/ascon_pack.sv | 26 ++
 rtl/compteur_bloc.sv | 28 ++
 rtl/fsm_ascon_encrypt.sv | 188 ++++++++++++++++++
 tb/tb_fsm_ascon_encrypt.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - Shared FSM state type and round constants for the Ascon-128 control path
package ascon_pack;

  typedef enum logic [3:0] {
    IDLE,
    CONF_INIT,
    INIT,
    WAIT_AD,
    CONF_AD,
    AD,
    WAIT_PT,
    CONF_PT,
    PT,
    CONF_FIN,
    FIN,
    DONE
  } state_fsm_t;

  localparam logic [3:0] ROUND_LAST = 4'd11;
  localparam logic [3:0] ROUND_P6   = 4'd6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/compteur_bloc.sv
// rtl/compteur_bloc.sv - Block counter with enable, clear and last-block flag
module compteur_bloc #(
  parameter int WIDTH = 2
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;

  // Clear wins over increment: the last block of a phase both counts and resets.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == limit_i);

endmodule

// File: rtl/fsm_ascon_encrypt.sv
// rtl/fsm_ascon_encrypt.sv - Ascon-128 encryption control FSM (init, AD, PT, finalisation)
module fsm_ascon_encrypt
  import ascon_pack::*;
#(
  parameter int N_AD = 1,
  parameter int N_PT = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [3:0] round_i,
  output logic       en_cpt_perm_o,
  output logic       init_p12_o,
  output logic       init_p6_o,
  output logic       input_mode_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_b_o,
  output logic       en_xor_key_b_o,
  output logic       en_xor_key_e_o,
  output logic       en_xor_lsb_e_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       data_ready_o,
  output logic       cipher_valid_o,
  output logic       end_o
);

  localparam int CW = $clog2(max_int(N_AD, N_PT)) + 1;
  localparam logic [CW-1:0] LAST_AD = CW'(N_AD - 1);
  localparam logic [CW-1:0] LAST_PT = CW'(N_PT - 1);

  state_fsm_t    state_q, state_d;
  logic          cnt_en, cnt_clear, cnt_last;
  logic [CW-1:0] cnt_limit;
  logic          init_p12_c;
  logic          round_last;

  assign round_last = (round_i == ROUND_LAST);
  assign cnt_limit  = (state_q == WAIT_AD || state_q == CONF_AD || state_q == AD) ? LAST_AD : LAST_PT;

  compteur_bloc #(.WIDTH(CW)) u_compteur_bloc (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .en_i     (cnt_en),
    .clear_i  (cnt_clear),
    .limit_i  (cnt_limit),
    .last_o   (cnt_last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    en_cpt_perm_o   = 1'b0;
    init_p12_c      = 1'b0;
    init_p6_o       = 1'b0;
    input_mode_o    = 1'b0;
    en_reg_state_o  = 1'b0;
    en_xor_data_b_o = 1'b0;
    en_xor_key_b_o  = 1'b0;
    en_xor_key_e_o  = 1'b0;
    en_xor_lsb_e_o  = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    data_ready_o    = 1'b0;
    end_o           = 1'b0;
    cnt_en          = 1'b0;
    cnt_clear       = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        end_o = (state_q == DONE);
        if (start_i) begin
          init_p12_c = 1'b1;
          state_d    = CONF_INIT;
        end
      end
      CONF_INIT: begin
        en_reg_state_o = 1'b1;
        en_cpt_perm_o  = 1'b1;
        state_d        = INIT;
      end
      INIT: begin
        input_mode_o   = 1'b1;
        en_reg_state_o = 1'b1;
        if (round_last) begin
          en_xor_key_e_o = 1'b1;
          cnt_clear      = 1'b1;
          state_d        = WAIT_AD;
        end else begin
          en_cpt_perm_o = 1'b1;
        end
      end
      WAIT_AD: begin
        init_p6_o    = 1'b1;
        data_ready_o = 1'b1;
        if (data_valid_i) state_d = CONF_AD;
      end
      CONF_AD: begin
        input_mode_o    = 1'b1;
        en_xor_data_b_o = 1'b1;
        en_reg_state_o  = 1'b1;
        en_cpt_perm_o   = 1'b1;
        state_d         = AD;
      end
      AD: begin
        input_mode_o   = 1'b1;
        en_reg_state_o = 1'b1;
        if (round_last) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            en_xor_lsb_e_o = 1'b1;
            cnt_clear      = 1'b1;
            state_d        = WAIT_PT;
          end else begin
            state_d = WAIT_AD;
          end
        end else begin
          en_cpt_perm_o = 1'b1;
        end
      end
      // The last PT block is absorbed by the p12 finalisation, so preload round 0.
      WAIT_PT: begin
        data_ready_o = 1'b1;
        init_p12_c   = cnt_last;
        init_p6_o    = !cnt_last;
        if (data_valid_i) state_d = cnt_last ? CONF_FIN : CONF_PT;
      end
      CONF_PT: begin
        input_mode_o    = 1'b1;
        en_xor_data_b_o = 1'b1;
        en_cipher_o     = 1'b1;
        en_reg_state_o  = 1'b1;
        en_cpt_perm_o   = 1'b1;
        state_d         = PT;
      end
      PT: begin
        input_mode_o   = 1'b1;
        en_reg_state_o = 1'b1;
        if (round_last) begin
          cnt_en  = 1'b1;
          state_d = WAIT_PT;
        end else begin
          en_cpt_perm_o = 1'b1;
        end
      end
      CONF_FIN: begin
        input_mode_o    = 1'b1;
        en_xor_data_b_o = 1'b1;
        en_xor_key_b_o  = 1'b1;
        en_cipher_o     = 1'b1;
        en_reg_state_o  = 1'b1;
        en_cpt_perm_o   = 1'b1;
        state_d         = FIN;
      end
      FIN: begin
        input_mode_o   = 1'b1;
        en_reg_state_o = 1'b1;
        if (round_last) begin
          en_xor_key_e_o = 1'b1;
          en_tag_o       = 1'b1;
          state_d        = DONE;
        end else begin
          en_cpt_perm_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // start_i reaches init_p12 combinationally; keep it quiet while reset is held.
  assign init_p12_o = init_p12_c & resetb_i;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cipher_valid_o <= 1'b0;
    end else begin
      cipher_valid_o <= en_cipher_o;
    end
  end

endmodule

// File: tb/tb_fsm_ascon_encrypt.sv
// tb/tb_fsm_ascon_encrypt.sv - Self-checking bench for fsm_ascon_encrypt against a phase timeline model
module tb_fsm_ascon_encrypt;

  localparam logic [11:0] M_P12   = 12'h001;
  localparam logic [11:0] M_P6    = 12'h002;
  localparam logic [11:0] M_CPT   = 12'h004;
  localparam logic [11:0] M_REG   = 12'h008;
  localparam logic [11:0] M_DATAB = 12'h010;
  localparam logic [11:0] M_KEYB  = 12'h020;
  localparam logic [11:0] M_KEYE  = 12'h040;
  localparam logic [11:0] M_LSB   = 12'h080;
  localparam logic [11:0] M_CIPH  = 12'h100;
  localparam logic [11:0] M_TAG   = 12'h200;
  localparam logic [11:0] M_READY = 12'h400;
  localparam logic [11:0] M_END   = 12'h800;

  typedef struct packed {
    logic [11:0] v;
    logic        im;
    logic        im_chk;
    logic [3:0]  rnd;
    logic        rnd_chk;
    logic        st;
    logic        dv;
  } ent_t;

  logic clock_i, resetb_i, start_i, data_valid_i;
  logic [3:0] rc1, rc2;

  logic d1_cpt, d1_p12, d1_p6, d1_im, d1_reg, d1_datab, d1_keyb, d1_keye, d1_lsb, d1_ciph, d1_tag, d1_ready, d1_cv, d1_end;
  logic d2_cpt, d2_p12, d2_p6, d2_im, d2_reg, d2_datab, d2_keyb, d2_keye, d2_lsb, d2_ciph, d2_tag, d2_ready, d2_cv, d2_end;
  logic [11:0] obs1, obs2;

  assign obs1 = {d1_end, d1_ready, d1_tag, d1_ciph, d1_lsb, d1_keye, d1_keyb, d1_datab, d1_reg, d1_cpt, d1_p6, d1_p12};
  assign obs2 = {d2_end, d2_ready, d2_tag, d2_ciph, d2_lsb, d2_keye, d2_keyb, d2_datab, d2_reg, d2_cpt, d2_p6, d2_p12};

  fsm_ascon_encrypt dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .data_valid_i(data_valid_i), .round_i(rc1),
    .en_cpt_perm_o(d1_cpt), .init_p12_o(d1_p12), .init_p6_o(d1_p6), .input_mode_o(d1_im),
    .en_reg_state_o(d1_reg), .en_xor_data_b_o(d1_datab), .en_xor_key_b_o(d1_keyb), .en_xor_key_e_o(d1_keye),
    .en_xor_lsb_e_o(d1_lsb), .en_cipher_o(d1_ciph), .en_tag_o(d1_tag), .data_ready_o(d1_ready),
    .cipher_valid_o(d1_cv), .end_o(d1_end)
  );

  fsm_ascon_encrypt #(.N_AD(2), .N_PT(1)) dut2 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .data_valid_i(data_valid_i), .round_i(rc2),
    .en_cpt_perm_o(d2_cpt), .init_p12_o(d2_p12), .init_p6_o(d2_p6), .input_mode_o(d2_im),
    .en_reg_state_o(d2_reg), .en_xor_data_b_o(d2_datab), .en_xor_key_b_o(d2_keyb), .en_xor_key_e_o(d2_keye),
    .en_xor_lsb_e_o(d2_lsb), .en_cipher_o(d2_ciph), .en_tag_o(d2_tag), .data_ready_o(d2_ready),
    .cipher_valid_o(d2_cv), .end_o(d2_end)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // External round counters: load 0 / load 6 / increment.
  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) rc1 <= 4'd0;
    else if (d1_p12) rc1 <= 4'd0;
    else if (d1_p6) rc1 <= 4'd6;
    else if (d1_cpt) rc1 <= rc1 + 4'd1;
  end

  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) rc2 <= 4'd0;
    else if (d2_p12) rc2 <= 4'd0;
    else if (d2_p6) rc2 <= 4'd6;
    else if (d2_cpt) rc2 <= rc2 + 4'd1;
  end

  int n_checks = 0;
  int n_fail = 0;
  int dv_mode = 0;
  bit st_noise = 0;
  ent_t exp_q[$];
  int cnt_lsb, cnt_ciph, cnt_cv, cnt_tag, last_acc, first_end;

  function automatic logic stn();
    return st_noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic push(input logic [11:0] v, input logic im, input logic imc, input int rnd,
                      input logic rchk, input logic st);
    ent_t e;
    e.v = v; e.im = im; e.im_chk = imc; e.rnd = 4'(rnd); e.rnd_chk = rchk; e.st = st;
    e.dv = (dv_mode == 1) ? 1'b1 : (dv_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_phase(input logic [11:0] ld, input int d);
    for (int j = 0; j < d; j++) begin
      push(ld | M_READY, 1'b0, 1'b0, 0, 1'b0, stn());
      exp_q[exp_q.size()-1].dv = 1'b0;
    end
    push(ld | M_READY, 1'b0, 1'b0, 0, 1'b0, stn());
    exp_q[exp_q.size()-1].dv = 1'b1;
  endtask

  task automatic perm_rounds(input int first, input logic [11:0] last_extra);
    for (int r = first; r <= 10; r++) push(M_REG | M_CPT, 1'b1, 1'b1, r, 1'b1, stn());
    push(M_REG | last_extra, 1'b1, 1'b1, 11, 1'b1, stn());
  endtask

  // Expected per-cycle timeline of one full encryption, built phase by phase.
  task automatic build_run(input int nad, input int npt, input bit from_done, input int maxw,
                           input int pt_w0, input int ndone);
    exp_q.delete();
    push(M_P12 | (from_done ? M_END : 12'h000), 1'b0, 1'b0, 0, 1'b0, 1'b1);
    push(M_CPT | M_REG, 1'b0, 1'b1, 0, 1'b1, stn());
    perm_rounds(1, M_KEYE);
    for (int b = 0; b < nad; b++) begin
      wait_phase(M_P6, int'($urandom_range(0, maxw)));
      push(M_DATAB | M_REG | M_CPT, 1'b1, 1'b1, 6, 1'b1, stn());
      perm_rounds(7, (b == nad - 1) ? M_LSB : 12'h000);
    end
    for (int b = 0; b < npt - 1; b++) begin
      wait_phase(M_P6, (b == 0 && pt_w0 >= 0) ? pt_w0 : int'($urandom_range(0, maxw)));
      push(M_DATAB | M_CIPH | M_REG | M_CPT, 1'b1, 1'b1, 6, 1'b1, stn());
      perm_rounds(7, 12'h000);
    end
    wait_phase(M_P12, (npt == 1 && pt_w0 >= 0) ? pt_w0 : int'($urandom_range(0, maxw)));
    push(M_DATAB | M_KEYB | M_CIPH | M_REG | M_CPT, 1'b1, 1'b1, 0, 1'b1, stn());
    perm_rounds(1, M_KEYE | M_TAG);
    for (int i = 0; i < ndone; i++) push(M_END, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_q(input string tag, input int stop_at, input bit sel);
    logic prev_ciph;
    logic [11:0] o;
    logic cv, im;
    logic [3:0] r;
    prev_ciph = 1'b0;
    cnt_lsb = 0; cnt_ciph = 0; cnt_cv = 0; cnt_tag = 0; last_acc = -1; first_end = -1;
    for (int k = 0; k < exp_q.size() && k < stop_at; k++) begin
      start_i = exp_q[k].st;
      data_valid_i = exp_q[k].dv;
      @(negedge clock_i);
      o  = sel ? obs2 : obs1;
      cv = sel ? d2_cv : d1_cv;
      im = sel ? d2_im : d1_im;
      r  = sel ? rc2 : rc1;
      n_checks++;
      if (o !== exp_q[k].v) begin
        n_fail++;
        $display("FAIL %s outputs cycle=%0d got=%03h exp=%03h", tag, k, o, exp_q[k].v);
      end
      n_checks++;
      if (cv !== prev_ciph) begin
        n_fail++;
        $display("FAIL %s cipher_valid cycle=%0d got=%b exp=%b", tag, k, cv, prev_ciph);
      end
      if (exp_q[k].im_chk) begin
        n_checks++;
        if (im !== exp_q[k].im) begin
          n_fail++;
          $display("FAIL %s input_mode cycle=%0d got=%b exp=%b", tag, k, im, exp_q[k].im);
        end
      end
      if (exp_q[k].rnd_chk) begin
        n_checks++;
        if (r !== exp_q[k].rnd) begin
          n_fail++;
          $display("FAIL %s round cycle=%0d got=%0d exp=%0d", tag, k, r, exp_q[k].rnd);
        end
      end
      cnt_lsb  += int'(o[7]);
      cnt_ciph += int'(o[8]);
      cnt_tag  += int'(o[9]);
      cnt_cv   += int'(cv);
      if (o[10] && exp_q[k].dv) last_acc = k;
      if (o[11] && first_end < 0) first_end = k;
      prev_ciph = exp_q[k].v[8];
      @(posedge clock_i);
      #1;
    end
    start_i = 1'b0;
    data_valid_i = 1'b0;
  endtask

  task automatic check_count(input string name, input int got, input int exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  task automatic do_reset();
    resetb_i = 1'b0;
    start_i = 1'b0;
    data_valid_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    resetb_i = 1'b1;
  endtask

  task automatic test_reset();
    resetb_i = 1'b0;
    start_i = 1'b1;
    data_valid_i = 1'b1;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    check_count("reset_outputs_dut", int'(obs1), 0);
    check_count("reset_outputs_dut2", int'(obs2), 0);
    check_count("reset_cipher_valid", int'(d1_cv | d2_cv | d1_im | d2_im), 0);
    @(posedge clock_i);
    #1;
    resetb_i = 1'b1;
    dv_mode = 0; st_noise = 0;
    build_run(1, 4, 1'b0, 3, -1, 3);
    run_q("init_timing", exp_q.size(), 1'b0);
  endtask

  task automatic test_held_valid();
    do_reset();
    dv_mode = 1; st_noise = 0;
    build_run(1, 4, 1'b0, 0, -1, 3);
    run_q("held_valid", exp_q.size(), 1'b0);
    check_count("held_lsb_count", cnt_lsb, 1);
    check_count("held_cipher_count", cnt_ciph, 4);
    check_count("held_cipher_valid_count", cnt_cv, 4);
    check_count("held_tag_count", cnt_tag, 1);
    check_count("held_end_latency", first_end - last_acc, 13);
  endtask

  task automatic test_withheld();
    do_reset();
    dv_mode = 0; st_noise = 0;
    build_run(1, 4, 1'b0, 2, 20, 2);
    run_q("withheld", exp_q.size(), 1'b0);
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    dv_mode = 2; st_noise = 1;
    build_run(1, 4, 1'b0, 5, -1, 2);
    run_q("ignored_inputs", exp_q.size(), 1'b0);
    check_count("ignored_lsb_count", cnt_lsb, 1);
    check_count("ignored_tag_count", cnt_tag, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    dv_mode = 2; st_noise = 1;
    build_run(1, 4, 1'b0, 4, -1, 2);
    run_q("b2b_first", exp_q.size(), 1'b0);
    for (int i = 0; i < 3; i++) begin
      build_run(1, 4, 1'b1, 4, -1, int'($urandom_range(1, 4)));
      run_q("b2b_restart", exp_q.size(), 1'b0);
      check_count("b2b_cipher_count", cnt_ciph, 4);
    end
  endtask

  task automatic test_reset_mid_fin();
    int r3;
    do_reset();
    dv_mode = 2; st_noise = 1;
    build_run(1, 4, 1'b0, 3, -1, 2);
    r3 = exp_q.size() - 1 - 2 - 8;
    run_q("pre_reset", r3, 1'b0);
    check_count("fin_round_before_reset", int'(rc1), 3);
    resetb_i = 1'b0;
    #2;
    check_count("midfin_reset_outputs", int'(obs1), 0);
    check_count("midfin_reset_end", int'(d1_end | d1_cv), 0);
    @(posedge clock_i);
    #1;
    resetb_i = 1'b1;
    build_run(1, 4, 1'b0, 3, -1, 2);
    run_q("after_reset", exp_q.size(), 1'b0);
    check_count("after_reset_tag_count", cnt_tag, 1);
  endtask

  task automatic test_short_params();
    do_reset();
    dv_mode = 2; st_noise = 1;
    build_run(2, 1, 1'b0, 4, -1, 2);
    run_q("nad2_npt1", exp_q.size(), 1'b1);
    check_count("short_lsb_count", cnt_lsb, 1);
    check_count("short_cipher_count", cnt_ciph, 1);
    check_count("short_tag_count", cnt_tag, 1);
  endtask

  initial begin
    resetb_i = 1'b0;
    start_i = 1'b0;
    data_valid_i = 1'b0;
    test_reset();
    test_held_valid();
    test_withheld();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid_fin();
    test_short_params();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
